// File: rtl/jk_moore_scheduler.sv
// Round-robin scheduler sharing one JK-style Moore machine among NREQ requesters.
// Optional JKS_PREDICT_EN adds a sticky predicted-vs-observed mismatch flag on err.
module jk_moore_scheduler #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       cmd,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    rd_y,
  output logic [$clog2(NREQ)-1:0] last_id,
  output logic                    busy,
  output logic                    j,
  output logic                    k,
  input  logic                    y,
  output logic                    err
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned MAXC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0]  HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IDW-1:0] ID_MAX      = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;
  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [IDW-1:0] id, rr_ptr, sel;
  cmd_t           cmd_r, cmd_sel;
  logic           found;
  logic           sample;

  // First requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found   = 1'b0;
    sel     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr) + i) % NREQ;
      if (!found && req[IDW'(idx)]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
    cmd_sel = cmd_t'(2'(cmd >> {sel, 1'b0}));
  end

  assign sample = (state == SETTLE) && (cnt == SETTLE_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt     = '0;
    done    = '0;
    j       = 1'b0;
    k       = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        busy  = 1'b0;
        cnt_n = '0;
        if (found) state_n = DRIVE;
      end
      DRIVE: begin
        if (cnt == '0) gnt = NREQ'(1) << id;
        case (cmd_r)
          CMD_SET:   j = 1'b1;
          CMD_RESET: k = 1'b1;
          CMD_TOGGLE: begin
            j = (cnt == '0);
            k = (cnt == '0);
          end
          default: ;
        endcase
        if (cnt == HOLD_LAST) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        done    = NREQ'(1) << id;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // last_id and rr_ptr are latched with rd_y so all three are valid during the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      id      <= '0;
      cmd_r   <= CMD_HOLD;
      rr_ptr  <= '0;
      rd_y    <= 1'b0;
      last_id <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && found) begin
        id    <= sel;
        cmd_r <= cmd_sel;
      end
      if (sample) begin
        rd_y    <= y;
        last_id <= id;
        rr_ptr  <= (id == ID_MAX) ? '0 : id + IDW'(1);
      end
    end
  end

`ifdef JKS_PREDICT_EN
  logic pred;

  always_ff @(posedge clk) begin
    if (rst) begin
      pred <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (state == DRIVE && cnt == HOLD_LAST) begin
        case (cmd_r)
          CMD_SET:    pred <= 1'b1;
          CMD_RESET:  pred <= 1'b0;
          CMD_TOGGLE: pred <= ~pred;
          default:    ;
        endcase
      end
      if (sample && (y != pred)) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_moore_scheduler.sv
// Bench for jk_moore_scheduler: two parameterisations against a transaction-timeline model.
module tb_jk_moore_scheduler;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int H0 = 1, S0 = 1, H1 = 3, S1 = 2;
`ifdef JKS_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] cmd = '0;
  logic           force_y0 = 1'b0;
  bit             started = 1'b0;

  logic [N-1:0]   gntw  [2];
  logic [N-1:0]   donew [2];
  logic [IDW-1:0] lastw [2];
  logic [1:0]     jw, kw, yq, yin, busyw, rdw, errw;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jk_moore_scheduler #(.NREQ(N), .HOLD_CYCLES(H0), .SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .gnt(gntw[0]), .done(donew[0]),
    .rd_y(rdw[0]), .last_id(lastw[0]), .busy(busyw[0]), .j(jw[0]), .k(kw[0]),
    .y(yin[0]), .err(errw[0]));

  jk_moore_scheduler #(.NREQ(N), .HOLD_CYCLES(H1), .SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .gnt(gntw[1]), .done(donew[1]),
    .rd_y(rdw[1]), .last_id(lastw[1]), .busy(busyw[1]), .j(jw[1]), .k(kw[1]),
    .y(yin[1]), .err(errw[1]));

  // The Moore machines being driven (share rst with the scheduler)
  function automatic logic jk_next(input logic q, input logic jj, input logic kk);
    case ({jj, kk})
      2'b10:   return 1'b1;
      2'b01:   return 1'b0;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  always @(posedge clk) begin
    yq[0] <= rst ? 1'b0 : jk_next(yq[0], jw[0], kw[0]);
    yq[1] <= rst ? 1'b0 : jk_next(yq[1], jw[1], kw[1]);
  end
  assign yin = force_y0 ? 2'b00 : yq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a command is a timeline; ph counts cycles from the grant (ph=1)
  typedef struct {
    bit       act;
    int       ph;
    int       id;
    bit [1:0] c;
    int       rr;
    bit       q;
    bit       rd;
    int       last;
    bit       er;
  } mdl_t;
  mdl_t m [2];

  function automatic int hc(input int i);
    return (i == 0) ? H0 : H1;
  endfunction
  function automatic int sc(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic void mstep(input int i);
    int h, s;
    h = hc(i);
    s = sc(i);
    if (rst) begin
      m[i] = '{default: 0};
      return;
    end
    if (!m[i].act) begin
      for (int o = 0; o < N; o++) begin
        int r;
        r = (m[i].rr + o) % N;
        if (req[r[IDW-1:0]]) begin
          m[i].act = 1'b1;
          m[i].ph  = 1;
          m[i].id  = r;
          m[i].c   = 2'(cmd >> (2 * r));
          break;
        end
      end
    end else begin
      if (m[i].ph == h) begin
        case (m[i].c)
          2'b10:   m[i].q = 1'b1;
          2'b01:   m[i].q = 1'b0;
          2'b11:   m[i].q = ~m[i].q;
          default: ;
        endcase
      end
      if (m[i].ph == h + s) begin
        m[i].rd   = force_y0 ? 1'b0 : m[i].q;
        m[i].last = m[i].id;
        m[i].rr   = (m[i].id + 1) % N;
        if (PRED && (m[i].rd != m[i].q)) m[i].er = 1'b1;
      end
      if (m[i].ph == h + s + 1) m[i].act = 1'b0;
      else m[i].ph++;
    end
  endfunction

  always @(posedge clk) begin
    mstep(0);
    mstep(1);
  end

  always @(negedge clk) begin : cmp
    int h, s;
    logic [31:0] eg, ed;
    bit drv, ej, ek;
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        h   = hc(i);
        s   = sc(i);
        eg  = (m[i].act && m[i].ph == 1) ? (32'd1 << m[i].id) : 32'd0;
        ed  = (m[i].act && m[i].ph == h + s + 1) ? (32'd1 << m[i].id) : 32'd0;
        drv = m[i].act && (m[i].ph <= h);
        ej  = drv && (m[i].c == 2'b10 || (m[i].c == 2'b11 && m[i].ph == 1));
        ek  = drv && (m[i].c == 2'b01 || (m[i].c == 2'b11 && m[i].ph == 1));
        chk($sformatf("gnt%0d", i), gntw[i], eg);
        chk($sformatf("done%0d", i), donew[i], ed);
        chk($sformatf("busy%0d", i), busyw[i], m[i].act);
        chk($sformatf("j%0d", i), jw[i], ej);
        chk($sformatf("k%0d", i), kw[i], ek);
        chk($sformatf("rd_y%0d", i), rdw[i], m[i].rd);
        chk($sformatf("last_id%0d", i), lastw[i], m[i].last);
        chk($sformatf("err%0d", i), errw[i], m[i].er);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic look();
    #3;
  endtask
  task automatic idle(input int n);
    req = '0;
    repeat (n) cyc();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  initial begin
    int jk0, jk1, g1, d1, d0;
    bit [4:0] rd_tab;
    rd_tab = 5'b11001;
    jk0 = 0; jk1 = 0; g1 = 0; d1 = 0; d0 = 0;

    repeat (3) cyc();
    rst = 1'b0;
    started = 1'b1;
    look();
    for (int i = 0; i < 2; i++) begin
      chk("rst_gnt", gntw[i], 0);
      chk("rst_done", donew[i], 0);
      chk("rst_busy", busyw[i], 0);
      chk("rst_jk", {jw[i], kw[i]}, 0);
      chk("rst_rd_y", rdw[i], 0);
      chk("rst_last_id", lastw[i], 0);
      chk("rst_err", errw[i], 0);
    end

    // Single set command on requester 0
    cyc(); req = 4'b0001; cmd = 8'b00_00_00_10;
    cyc(); req = '0; look();
    chk("t1_gnt", gntw[0], 4'b0001);
    chk("t1_j", jw[0], 1);
    chk("t1_k", kw[0], 0);
    chk("t1_busy", busyw[0], 1);
    cyc(); look();
    chk("t1_j_off", jw[0], 0);
    chk("t1_done_early", donew[0], 0);
    cyc(); look();
    chk("t1_done", donew[0], 4'b0001);
    chk("t1_rd_y", rdw[0], 1);
    chk("t1_last_id", lastw[0], 0);
    cyc(); look();
    chk("t1_busy_fall", busyw[0], 0);
    idle(8);

    // Two toggles on requester 2 from y=0
    do_reset();
    req = 4'b0100; cmd = 8'b00_11_00_00;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c == 8) req = '0;
      look();
      jk0 += int'(jw[0] & kw[0]);
      jk1 += int'(jw[1] & kw[1]);
      if (c == 3) chk("t2_rd_first", rdw[0], 1);
      if (c == 7) begin
        chk("t2_done_second", donew[0], 4'b0100);
        chk("t2_rd_second", rdw[0], 0);
      end
      if (c == 13) chk("t2_done_h3", donew[1], 4'b0100);
    end
    chk("t2_toggles_h1", jk0, 2);
    chk("t2_toggles_h3", jk1, 2);
    chk("t2_rd_h3", rdw[1], 0);

    // All four requesting: set/reset/hold/toggle
    idle(4);
    do_reset();
    req = 4'b1111; cmd = 8'b11_00_01_10;
    for (int c = 1; c <= 19; c++) begin
      cyc();
      if (c == 18) req = '0;
      look();
      if (c % 4 == 1) chk($sformatf("t3_gnt_c%0d", c), gntw[0], 1 << (((c - 1) / 4) % 4));
      if (c % 4 == 3) begin
        chk($sformatf("t3_done_c%0d", c), donew[0], 1 << (((c - 3) / 4) % 4));
        chk($sformatf("t3_rd_c%0d", c), rdw[0], rd_tab[(c - 3) / 4]);
      end
    end

    // Reset during DRIVE with rr_ptr non-zero
    cyc(); req = 4'b0100; cmd = 8'b00_10_01_10;
    cyc(); req = '0; rst = 1'b1; look();
    chk("t4_gnt", gntw[0], 4'b0100);
    chk("t4_j_drive", jw[0], 1);
    cyc(); rst = 1'b0; look();
    chk("t4_jk_after_rst", {jw[0], kw[0]}, 0);
    chk("t4_busy_after_rst", busyw[0], 0);
    chk("t4_busy_h3_after_rst", busyw[1], 0);
    cyc(); req = 4'b0011; look();
    chk("t4_no_done", donew[0], 0);
    cyc(); req = '0; look();
    chk("t4_gnt_from_zero", gntw[0], 4'b0001);
    idle(10);

    // Requester 1 withdraws before being granted
    cyc(); req = 4'b0001; cmd = '0;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c == 1) req = 4'b0010;
      if (c == 2) req = '0;
      look();
      g1 += int'(gntw[0][1]) + int'(gntw[1][1]);
      d1 += int'(donew[0][1]) + int'(donew[1][1]);
      d0 += int'(donew[0][0]);
    end
    chk("t5_gnt1_count", g1, 0);
    chk("t5_done1_count", d1, 0);
    chk("t5_done0_count", d0, 1);

    // y forced low after a set command
    idle(2);
    cyc(); req = 4'b0001; cmd = 8'b00_00_00_10; force_y0 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 1) req = '0;
      if (c == 8) force_y0 = 1'b0;
      look();
      if (c == 3) begin
        chk("t6_done", donew[0], 4'b0001);
        chk("t6_rd_y", rdw[0], 0);
        chk("t6_err", errw[0], PRED);
      end
      if (c == 6) chk("t6_err_h3", errw[1], PRED);
    end
    idle(4);
    look();
    chk("t6_err_sticky", errw[0], PRED);
    do_reset();
    look();
    chk("t6_err_cleared", errw[0], 0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst      = ($urandom_range(0, 199) == 0);
      req      = N'($urandom);
      cmd      = (2 * N)'($urandom);
      force_y0 = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    force_y0 = 1'b0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
